uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 2: idle cycles enforced between consecutive bytes; legal range 0..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: cycles allowed for uart_tx_sending to rise after launch; legal range 2..65535.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req0_valid  in  1  SD-path requester has a byte.
REQ-006 req0_data  in  8  SD-path byte.
REQ-007 req0_ready  out  1  SD-path byte accepted this cycle when high with req0_valid.
REQ-008 req1_valid  in  1  status/echo requester has a byte.
REQ-009 req1_data  in  8  status/echo byte.
REQ-010 req1_ready  out  1  status/echo byte accepted this cycle when high with req1_valid.
REQ-011 uart_tx_en  out  1  one-cycle start pulse to UART transmitter (ctrl bit TX_EN).
REQ-012 uart_tx_data  out  8  byte to transmit, held stable from launch until return to IDLE.
REQ-013 uart_tx_sending  in  1  UART transmitter busy (ctrl bit TX_SENDING).
REQ-014 grant  out  2  one-hot owner of current transfer ({req1,req0}); 2'b00 when idle.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout_err  out  1  sticky flag: UART never reported sending.
REQ-017 err_clr  in  1  synchronous clear of timeout_err.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, SENDING, GUARD.
REQ-019 IDLE: readies are combinational; at most one ready high; no ready high while uart_tx_sending=1.
REQ-020 Selection: only one valid -> that requester; both valid -> requester not served last (round-robin pointer); pointer after reset favours req0.
REQ-021 On valid&ready in IDLE: capture data into uart_tx_data, set grant, update pointer to the served requester, go LAUNCH next cycle.
REQ-022 LAUNCH: uart_tx_en=1 for exactly one cycle (cycle after acceptance); go WAIT_BUSY.
REQ-023 WAIT_BUSY: uart_tx_sending=1 -> SENDING; else count; TIMEOUT_CYCLES cycles without sending -> set timeout_err, go GUARD.
REQ-024 SENDING: uart_tx_sending=0 -> GUARD; no cycle limit.
REQ-025 GUARD: remain GUARD_CYCLES cycles then IDLE; GUARD_CYCLES=0 -> IDLE on the next cycle (GUARD lasts one cycle).
REQ-026 grant cleared and uart_tx_data held on entry to IDLE; readies low in all non-IDLE states.
REQ-027 Counters 16-bit, reset to 0 on every state entry; no wrap reachable within legal parameter range.
REQ-028 Valid deasserted before ready: no transfer, no state change, pointer unchanged.
REQ-029 err_clr and timeout set in same cycle: set wins.
REQ-030 Minimum byte period = 1 (accept) + 1 (LAUNCH) + UART busy time + GUARD_CYCLES + handshake cycles.

Reset
REQ-031 rst high SHALL asynchronously force IDLE, uart_tx_en=0, uart_tx_data=8'h00, grant=2'b00, busy=0, timeout_err=0, counters=0, pointer=favour req0, readies low while rst high.
REQ-032 rst asserted mid-transfer SHALL abandon the byte without a further uart_tx_en pulse; first acceptance allowed the first clock edge after rst falls.

Verification
REQ-033 Single: req0_valid=1, data=8'hA5, UART sends 10 cycles -> req0_ready cycle N, uart_tx_en cycle N+1 only, uart_tx_data=8'hA5 throughout, grant=2'b01, IDLE after GUARD of 2.
REQ-034 Contention: both valid continuously, req0=8'h11, req1=8'h22 -> UART sees 11,22,11,22; readies never high together.
REQ-035 Timeout: req1 byte, uart_tx_sending held 0 -> timeout_err=1 after 1024 WAIT_BUSY cycles, IDLE after guard; err_clr pulse -> 0.
REQ-036 External busy: uart_tx_sending=1 while idle with req0_valid=1 -> req0_ready held 0 until sending falls.
REQ-037 Reset mid-SENDING: rst pulse -> all outputs at reset values immediately, no uart_tx_en; next req1 byte accepted normally.
REQ-038 GUARD_CYCLES=0 build: back-to-back req0 bytes -> next acceptance 2 cycles after uart_tx_sending falls.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one byte-wide UART transmitter between two requesters:
//   req0 : SD-path byte stream
//   req1 : status / echo byte stream
//
// A byte is accepted in IDLE with a valid/ready handshake. It is then launched
// with a one-cycle uart_tx_en pulse. The arbiter waits for the UART to report
// sending and then waits for it to finish. A guard gap follows before the next
// byte is accepted. When both requesters are valid they are served round-robin.
// If the UART never reports sending, the byte is abandoned and a sticky
// timeout_err flag is raised.
//
// Parameters
//   GUARD_CYCLES    idle cycles between bytes (0..255); 0 still costs one cycle
//   TIMEOUT_CYCLES  WAIT_BUSY cycles allowed before timeout (2..65535)
//
// Ports
//   clk, rst          clock and asynchronous active-high reset
//   req0_valid/data   SD-path request;   req0_ready accepts it (IDLE only)
//   req1_valid/data   status request;    req1_ready accepts it (IDLE only)
//   uart_tx_en        one-cycle start pulse to the UART
//   uart_tx_data      byte being transmitted, held until the next acceptance
//   uart_tx_sending   UART busy indication
//   grant             one-hot owner of the current transfer {req1,req0}
//   busy              high whenever the arbiter is not in IDLE
//   timeout_err       sticky timeout flag
//   err_clr           synchronous clear of timeout_err (a timeout in the same
//                     cycle wins)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    input  logic       uart_tx_sending,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err,
    input  logic       err_clr
);

    // The limits are compared against count+1, so they get one bit of headroom.
    localparam logic [16:0] GUARD_LIMIT   = 17'(GUARD_CYCLES);
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_SENDING,
        S_GUARD
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [16:0] cnt_inc;
    logic        last_q;      // 1: req1 was served most recently
    logic [7:0]  data_q;
    logic [1:0]  grant_q;
    logic        err_q;
    logic        timeout_hit;
    logic        pick1;

    // cnt_inc is the number of cycles spent in the current state, including
    // this one. Comparing it with the limit makes the exit happen on the last
    // cycle of the state.
    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    // Round-robin choice. req1 is picked when it is the only valid requester,
    // or when both are valid and req0 was served last.
    assign pick1 = req1_valid && (!req0_valid || !last_q);

    assign uart_tx_data = data_q;
    assign grant        = grant_q;
    assign timeout_err  = err_q;

    // Next-state and output decode.
    always_comb begin
        // NOTE: every signal driven here gets a default before the case, so no
        // path through the block can leave one unassigned and infer a latch.
        state_d     = state_q;
        timeout_hit = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        uart_tx_en  = 1'b0;
        busy        = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                // Readies stay low while the UART is busy with traffic that
                // bypasses the arbiter. They also stay low while rst is held.
                if (!uart_tx_sending && !rst) begin
                    req0_ready = req0_valid && !pick1;
                    req1_ready = pick1;
                    if (req0_valid || req1_valid) begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                uart_tx_en = 1'b1;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_tx_sending) begin
                    state_d = S_SENDING;
                end else if (cnt_inc >= TIMEOUT_LIMIT) begin
                    timeout_hit = 1'b1;
                    state_d     = S_GUARD;
                end
            end
            S_SENDING: begin
                if (!uart_tx_sending) begin
                    state_d = S_GUARD;
                end
            end
            S_GUARD: begin
                // GUARD_CYCLES = 0 still spends one cycle here.
                if (cnt_inc >= GUARD_LIMIT) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, captured byte, grant, pointer and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            last_q  <= 1'b1;   // next contention favours req0
            data_q  <= 8'h00;
            grant_q <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register here updating
            // from the values before the edge, whatever order the lines are in.
            state_q <= state_d;

            // The counter restarts on every state change. It only runs in the
            // two states that measure time, so it cannot wrap.
            if (state_d != state_q) begin
                cnt_q <= 16'd0;
            end else if (state_q == S_WAIT_BUSY || state_q == S_GUARD) begin
                cnt_q <= cnt_inc[15:0];
            end

            if (req0_ready || req1_ready) begin
                data_q  <= req1_ready ? req1_data : req0_data;
                grant_q <= {req1_ready, req0_ready};
                last_q  <= req1_ready;
            end else if (state_q == S_GUARD && state_d == S_IDLE) begin
                grant_q <= 2'b00;
            end

            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter.
//   dut  : default build (GUARD_CYCLES=2, TIMEOUT_CYCLES=1024), driven by a
//          small UART model when uart_auto=1, else by force_sending.
//   g_dut: GUARD_CYCLES=0 build, with uart_tx_sending driven directly.
// Inputs change 1 ns after a rising edge. Outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_sending;
    logic [1:0] grant;
    logic       busy;
    logic       timeout_err;
    logic       err_clr = 1'b0;

    logic       g_req0_valid = 1'b0;
    logic [7:0] g_req0_data = 8'h00;
    logic       g_req0_ready;
    logic       g_req1_ready;
    logic       g_tx_en;
    logic [7:0] g_tx_data;
    logic       g_sending = 1'b0;
    logic [1:0] g_grant;
    logic       g_busy;
    logic       g_err;

    // UART model state
    logic       uart_auto = 1'b1;
    logic       force_sending = 1'b0;
    logic       model_sending = 1'b0;
    int         uart_len = 10;
    logic [7:0] sent[$];

    int pass_cnt = 0;
    int chk_cnt  = 0;

    assign uart_tx_sending = uart_auto ? model_sending : force_sending;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
        .uart_tx_sending(uart_tx_sending),
        .grant(grant), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    uart_tx_arbiter #(.GUARD_CYCLES(0), .TIMEOUT_CYCLES(1024)) g_dut (
        .clk(clk), .rst(rst),
        .req0_valid(g_req0_valid), .req0_data(g_req0_data), .req0_ready(g_req0_ready),
        .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(g_req1_ready),
        .uart_tx_en(g_tx_en), .uart_tx_data(g_tx_data),
        .uart_tx_sending(g_sending),
        .grant(g_grant), .busy(g_busy), .timeout_err(g_err), .err_clr(1'b0)
    );

    // UART model: records each launched byte, raises sending one cycle after
    // the launch pulse, and holds it for uart_len sampled edges.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_auto && uart_tx_en === 1'b1) begin
                sent.push_back(uart_tx_data);
                @(posedge clk);
                #1 model_sending = 1'b1;
                repeat (uart_len) @(posedge clk);
                #1 model_sending = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        chk_cnt++; if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL reset_readies: got %b want 00", {req1_ready, req0_ready}); else pass_cnt++;
        chk_cnt++; if (uart_tx_en !== 1'b0) $display("FAIL reset_tx_en: got %b want 0", uart_tx_en); else pass_cnt++;
        chk_cnt++; if (uart_tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", uart_tx_data); else pass_cnt++;
        chk_cnt++; if ({grant, busy, timeout_err} !== 4'b0000) $display("FAIL reset_grant_busy_err: got %b want 0000", {grant, busy, timeout_err}); else pass_cnt++;
        @(posedge clk);
        #1;
        chk_cnt++; if ({req1_ready, req0_ready, busy} !== 3'b000) $display("FAIL reset_held: got %b want 000", {req1_ready, req0_ready, busy}); else pass_cnt++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        int  busy_cycles;
        int  en_extra;
        int  data_bad;
        logic [7:0] first;
        uart_auto = 1'b1;
        uart_len  = 10;
        sent.delete();
        @(posedge clk);
        #1 req0_data = 8'hA5;
        req0_valid = 1'b1;
        @(negedge clk);
        chk_cnt++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL single_ready: got %b want 01", {req1_ready, req0_ready}); else pass_cnt++;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        req0_data = 8'h00;
        @(negedge clk);
        chk_cnt++; if ({uart_tx_en, busy, grant} !== 4'b1101) $display("FAIL single_launch: got %b want 1101", {uart_tx_en, busy, grant}); else pass_cnt++;
        chk_cnt++; if (uart_tx_data !== 8'hA5) $display("FAIL single_data: got %h want a5", uart_tx_data); else pass_cnt++;
        busy_cycles = 1;
        en_extra = 0;
        data_bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            busy_cycles++;
            if (uart_tx_en !== 1'b0) en_extra++;
            if (uart_tx_data !== 8'hA5) data_bad++;
        end
        // 1 launch + 1 wait + 10 sending + 2 guard
        chk_cnt++; if (busy_cycles !== 14) $display("FAIL single_busy_cycles: got %0d want 14", busy_cycles); else pass_cnt++;
        chk_cnt++; if (en_extra !== 0) $display("FAIL single_en_once: got %0d extra pulses want 0", en_extra); else pass_cnt++;
        chk_cnt++; if (data_bad !== 0) $display("FAIL single_data_held: got %0d bad cycles want 0", data_bad); else pass_cnt++;
        chk_cnt++; if ({grant, uart_tx_data} !== {2'b00, 8'hA5}) $display("FAIL single_idle: got grant=%b data=%h want 00 a5", grant, uart_tx_data); else pass_cnt++;
        first = (sent.size() > 0) ? sent[0] : 8'hxx;
        chk_cnt++; if (sent.size() != 1 || first !== 8'hA5) $display("FAIL single_uart_seen: got n=%0d byte=%h want 1 a5", sent.size(), first); else pass_cnt++;
    endtask

    task automatic test_contention();
        int overlap;
        bit ok;
        logic [31:0] seq;
        do_reset();
        sent.delete();
        uart_auto = 1'b1;
        uart_len  = 10;
        req0_data = 8'h11;
        req1_data = 8'h22;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk_cnt++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL rr_first_req0: got %b want 01", {req1_ready, req0_ready}); else pass_cnt++;
        overlap = 0;
        for (int i = 0; i < 200 && sent.size() < 4; i++) begin
            @(negedge clk);
            if (req0_ready === 1'b1 && req1_ready === 1'b1) overlap++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle(100, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL rr_drain: got busy=%b want 0 within budget", busy); else pass_cnt++;
        chk_cnt++; if (overlap !== 0) $display("FAIL rr_ready_overlap: got %0d cycles want 0", overlap); else pass_cnt++;
        seq = (sent.size() == 4) ? {sent[0], sent[1], sent[2], sent[3]} : 32'hxxxxxxxx;
        chk_cnt++; if (sent.size() != 4 || seq !== 32'h11221122) $display("FAIL rr_order: got n=%0d seq=%h want 4 11221122", sent.size(), seq); else pass_cnt++;
    endtask

    task automatic test_ext_busy();
        int bad;
        int busy_seen;
        bit ok;
        logic [7:0] first;
        sent.delete();
        @(posedge clk);
        #1 uart_auto = 1'b0;
        force_sending = 1'b1;
        req0_data = 8'h77;
        req0_valid = 1'b1;
        bad = 0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req0_ready !== 1'b0) bad++;
            if (busy !== 1'b0) busy_seen++;
        end
        chk_cnt++; if (bad !== 0) $display("FAIL extbusy_ready_low: got %0d high cycles want 0", bad); else pass_cnt++;
        chk_cnt++; if (busy_seen !== 0) $display("FAIL extbusy_stay_idle: got %0d busy cycles want 0", busy_seen); else pass_cnt++;
        // The requester withdraws before it was ever ready: nothing moves.
        @(posedge clk);
        #1 req0_valid = 1'b0;
        uart_auto = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        chk_cnt++; if (busy_seen !== 0 || sent.size() != 0) $display("FAIL withdraw_no_xfer: got busy=%0d sent=%0d want 0 0", busy_seen, sent.size()); else pass_cnt++;
        @(posedge clk);
        #1 uart_auto = 1'b0;
        force_sending = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        chk_cnt++; if (req0_ready !== 1'b0) $display("FAIL extbusy_blocked: got %b want 0", req0_ready); else pass_cnt++;
        @(posedge clk);
        #1 uart_auto = 1'b1;
        @(negedge clk);
        chk_cnt++; if (req0_ready !== 1'b1) $display("FAIL extbusy_release: got %b want 1", req0_ready); else pass_cnt++;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_idle(60, ok);
        first = (sent.size() > 0) ? sent[0] : 8'hxx;
        chk_cnt++; if (!ok || sent.size() != 1 || first !== 8'h77) $display("FAIL extbusy_xfer: got ok=%b n=%0d byte=%h want 1 1 77", ok, sent.size(), first); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int first_err;
        int idle_at;
        int en_cnt;
        logic err_a;
        logic err_b;
        @(posedge clk);
        #1 uart_auto = 1'b0;
        force_sending = 1'b0;
        err_clr = 1'b0;
        req1_data = 8'h3C;
        req1_valid = 1'b1;
        @(negedge clk);
        chk_cnt++; if (req1_ready !== 1'b1) $display("FAIL to_ready1: got %b want 1", req1_ready); else pass_cnt++;
        @(posedge clk);
        #1 req1_valid = 1'b0;
        first_err = 0;
        idle_at = 0;
        en_cnt = 0;
        for (int n = 1; n <= 1200; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk_cnt++; if (grant !== 2'b10) $display("FAIL to_grant: got %b want 10", grant); else pass_cnt++;
            end
            if (uart_tx_en === 1'b1) en_cnt++;
            if (first_err == 0 && timeout_err === 1'b1) first_err = n;
            if (busy === 1'b0) begin
                idle_at = n;
                break;
            end
        end
        // LAUNCH occupies sample 1, WAIT_BUSY samples 2..1025, then GUARD of 2.
        chk_cnt++; if (first_err !== 1026) $display("FAIL to_err_time: got %0d want 1026", first_err); else pass_cnt++;
        chk_cnt++; if (idle_at !== 1028) $display("FAIL to_idle_time: got %0d want 1028", idle_at); else pass_cnt++;
        chk_cnt++; if (en_cnt !== 1) $display("FAIL to_en_pulses: got %0d want 1", en_cnt); else pass_cnt++;
        chk_cnt++; if (grant !== 2'b00) $display("FAIL to_grant_clear: got %b want 00", grant); else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++; if (timeout_err !== 1'b1) $display("FAIL to_sticky: got %b want 1", timeout_err); else pass_cnt++;
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL to_clear: got %b want 0", timeout_err); else pass_cnt++;
        // Second timeout with err_clr held high: the set still wins.
        @(posedge clk);
        #1 err_clr = 1'b1;
        req1_valid = 1'b1;
        @(posedge clk);
        #1 req1_valid = 1'b0;
        err_a = 1'bx;
        err_b = 1'bx;
        for (int n = 1; n <= 1200; n++) begin
            @(negedge clk);
            if (n == 1026) err_a = timeout_err;
            if (n == 1027) err_b = timeout_err;
            if (busy === 1'b0) break;
        end
        err_clr = 1'b0;
        chk_cnt++; if ({err_a, err_b} !== 2'b10) $display("FAIL to_set_wins: got %b want 10", {err_a, err_b}); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int en_cnt;
        int rdy_cnt;
        bit ok;
        logic [7:0] first;
        @(posedge clk);
        #1 uart_auto = 1'b1;
        uart_len = 10;
        req0_data = 8'h5A;
        req0_valid = 1'b1;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk_cnt++; if ({busy, grant} !== 3'b101) $display("FAIL rstmid_in_flight: got %b want 101", {busy, grant}); else pass_cnt++;
        #1 rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk_cnt++; if ({busy, grant, uart_tx_en, timeout_err} !== 5'b00000) $display("FAIL rstmid_outputs: got %b want 00000", {busy, grant, uart_tx_en, timeout_err}); else pass_cnt++;
        chk_cnt++; if (uart_tx_data !== 8'h00 || {req1_ready, req0_ready} !== 2'b00) $display("FAIL rstmid_data_ready: got %h %b want 00 00", uart_tx_data, {req1_ready, req0_ready}); else pass_cnt++;
        sent.delete();
        en_cnt = 0;
        rdy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_tx_en !== 1'b0) en_cnt++;
            if (req0_ready !== 1'b0) rdy_cnt++;
            if (model_sending === 1'b0) break;
        end
        chk_cnt++; if (en_cnt !== 0 || rdy_cnt !== 0) $display("FAIL rstmid_quiet: got en=%0d rdy=%0d want 0 0", en_cnt, rdy_cnt); else pass_cnt++;
        req0_valid = 1'b0;
        #1 rst = 1'b0;
        req1_data = 8'hC3;
        req1_valid = 1'b1;
        #1;
        chk_cnt++; if (req1_ready !== 1'b1) $display("FAIL rstmid_ready_after: got %b want 1", req1_ready); else pass_cnt++;
        @(posedge clk);
        #1 req1_valid = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({uart_tx_en, grant, uart_tx_data} !== {1'b1, 2'b10, 8'hC3}) $display("FAIL rstmid_launch: got en=%b grant=%b data=%h want 1 10 c3", uart_tx_en, grant, uart_tx_data); else pass_cnt++;
        wait_idle(60, ok);
        first = (sent.size() > 0) ? sent[0] : 8'hxx;
        chk_cnt++; if (!ok || sent.size() != 1 || first !== 8'hC3) $display("FAIL rstmid_xfer: got ok=%b n=%0d byte=%h want 1 1 c3", ok, sent.size(), first); else pass_cnt++;
    endtask

    task automatic test_guard0();
        logic [2:0] rdy;
        @(posedge clk);
        #1 g_req0_data = 8'h01;
        g_req0_valid = 1'b1;
        @(negedge clk);
        chk_cnt++; if (g_req0_ready !== 1'b1) $display("FAIL g0_ready_first: got %b want 1", g_req0_ready); else pass_cnt++;
        @(posedge clk);
        #1 g_req0_data = 8'h02;
        @(negedge clk);
        chk_cnt++; if ({g_tx_en, g_tx_data} !== {1'b1, 8'h01}) $display("FAIL g0_launch1: got en=%b data=%h want 1 01", g_tx_en, g_tx_data); else pass_cnt++;
        @(posedge clk);
        #1 g_sending = 1'b1;
        repeat (3) @(posedge clk);
        #1 g_sending = 1'b0;
        @(negedge clk); rdy[2] = g_req0_ready;
        @(negedge clk); rdy[1] = g_req0_ready;
        @(negedge clk); rdy[0] = g_req0_ready;
        chk_cnt++; if (rdy !== 3'b001) $display("FAIL g0_reaccept_timing: got %b want 001", rdy); else pass_cnt++;
        @(posedge clk);
        #1 g_req0_valid = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({g_tx_en, g_tx_data} !== {1'b1, 8'h02}) $display("FAIL g0_launch2: got en=%b data=%h want 1 02", g_tx_en, g_tx_data); else pass_cnt++;
        @(posedge clk);
        #1 g_sending = 1'b1;
        @(posedge clk);
        #1 g_sending = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if ({g_busy, g_grant} !== 3'b000) $display("FAIL g0_idle: got %b want 000", {g_busy, g_grant}); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_ext_busy();
        test_timeout();
        test_guard0();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
